io_seq: RTL and testbench

I/O request sequencer, directly upstream of the fast-side bus cycle terminator. It turns CPU I/O-space cycles into single requests to the slow I/O bus master, and drives the `IOPWReady` and `IONPReady` strobes that the terminator combines into `nDTACK`/`nVPA`. Posted writes go into a one-deep buffer. Reads and non-postable writes stall until the I/O bus master finishes, or until a watchdog expires.

---
 rtl/io_seq.sv | 144 ++++++++++++++
 tb/tb_io_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/io_seq.sv
// I/O request sequencer: turns CPU I/O cycles into single requests to the slow I/O bus master, 1-cycle accept latency.
// One transfer in flight; CPU stalls (ready held low) until accepted/completed, with a watchdog as backstop.
module io_seq #(
  parameter int TIMEOUT = 1023
) (
  input  logic FCLK,
  input  logic nRES,
  input  logic BACT,
  input  logic IOCS,
  input  logic IOPWCS,
  input  logic IOACT,
  output logic IOREQ,
  output logic ALE,
  output logic RDLE,
  output logic IOPWReady,
  output logic IONPReady,
  output logic IOTimeout
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACT  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          ioact_s1_q, ioact_s2_q;
  logic          served_q, served_d;
  logic          np_q, np_d;
  logic          pwrdy_q, pwrdy_d;
  logic          nprdy_q, nprdy_d;
  logic          ioreq_q, ioreq_d;
  logic          ale_q, ale_d;
  logic          rdle_q, rdle_d;
  logic          tmo_q, tmo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic          pending;

  assign pending = BACT && IOCS && !served_q;
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d  = state_q;
    served_d = served_q;
    np_d     = np_q;
    pwrdy_d  = pwrdy_q;
    nprdy_d  = nprdy_q;
    cnt_d    = cnt_q;
    ioreq_d  = 1'b0;
    ale_d    = 1'b0;
    rdle_d   = 1'b0;
    tmo_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pending) begin
          state_d  = REQ;
          ale_d    = 1'b1;
          ioreq_d  = 1'b1;
          served_d = 1'b1;
          np_d     = !IOPWCS;
          pwrdy_d  = pwrdy_q | IOPWCS;
        end
      end
      REQ: begin
        cnt_d   = cnt_inc;
        ioreq_d = 1'b1;
        if (ioact_s2_q) begin
          state_d = ACT;
          ioreq_d = 1'b0;
        end
      end
      ACT: begin
        cnt_d = cnt_inc;
        if (!ioact_s2_q) begin
          state_d = IDLE;
          if (np_q) begin
            nprdy_d = 1'b1;
            rdle_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Watchdog overrides normal completion; a stalled non-posted CPU cycle is released without read data.
    if (state_q != IDLE && cnt_q == CNT_LAST) begin
      state_d = IDLE;
      ioreq_d = 1'b0;
      rdle_d  = 1'b0;
      tmo_d   = 1'b1;
      cnt_d   = '0;
      if (np_q) nprdy_d = 1'b1;
    end
    // End of the CPU bus cycle clears readies and re-arms acceptance; it wins over any same-edge set.
    if (!BACT) begin
      served_d = 1'b0;
      pwrdy_d  = 1'b0;
      nprdy_d  = 1'b0;
    end
  end

  always_ff @(posedge FCLK or negedge nRES) begin
    if (!nRES) begin
      state_q    <= IDLE;
      ioact_s1_q <= 1'b0;
      ioact_s2_q <= 1'b0;
      served_q   <= 1'b0;
      np_q       <= 1'b0;
      pwrdy_q    <= 1'b0;
      nprdy_q    <= 1'b0;
      ioreq_q    <= 1'b0;
      ale_q      <= 1'b0;
      rdle_q     <= 1'b0;
      tmo_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ioact_s1_q <= IOACT;
      ioact_s2_q <= ioact_s1_q;
      served_q   <= served_d;
      np_q       <= np_d;
      pwrdy_q    <= pwrdy_d;
      nprdy_q    <= nprdy_d;
      ioreq_q    <= ioreq_d;
      ale_q      <= ale_d;
      rdle_q     <= rdle_d;
      tmo_q      <= tmo_d;
      cnt_q      <= cnt_d;
    end
  end

  assign IOREQ     = ioreq_q;
  assign ALE       = ale_q;
  assign RDLE      = rdle_q;
  assign IOPWReady = pwrdy_q;
  assign IONPReady = nprdy_q;
  assign IOTimeout = tmo_q;

endmodule

// File: tb/tb_io_seq.sv
// Directed bench for io_seq: default-timeout instance for the main flows, TIMEOUT=8 instance for the watchdog.
module tb_io_seq;

  logic FCLK = 1'b0;
  logic nRES = 1'b0;
  logic BACT = 1'b0, IOCS = 1'b0, IOPWCS = 1'b0, IOACT = 1'b0;
  logic IOREQ, ALE, RDLE, IOPWReady, IONPReady, IOTimeout;
  logic IOREQ8, ALE8, RDLE8, IOPWReady8, IONPReady8, IOTimeout8;

  int ntotal = 0;
  int npass  = 0;

  always #5 FCLK = ~FCLK;

  io_seq dut (
    .FCLK(FCLK), .nRES(nRES), .BACT(BACT), .IOCS(IOCS), .IOPWCS(IOPWCS), .IOACT(IOACT),
    .IOREQ(IOREQ), .ALE(ALE), .RDLE(RDLE), .IOPWReady(IOPWReady), .IONPReady(IONPReady),
    .IOTimeout(IOTimeout)
  );

  io_seq #(.TIMEOUT(8)) dut8 (
    .FCLK(FCLK), .nRES(nRES), .BACT(BACT), .IOCS(IOCS), .IOPWCS(IOPWCS), .IOACT(IOACT),
    .IOREQ(IOREQ8), .ALE(ALE8), .RDLE(RDLE8), .IOPWReady(IOPWReady8), .IONPReady(IONPReady8),
    .IOTimeout(IOTimeout8)
  );

  // Output vector order: IOREQ, ALE, RDLE, IOPWReady, IONPReady, IOTimeout
  function automatic logic [5:0] outs();
    return {IOREQ, ALE, RDLE, IOPWReady, IONPReady, IOTimeout};
  endfunction

  function automatic logic [5:0] outs8();
    return {IOREQ8, ALE8, RDLE8, IOPWReady8, IONPReady8, IOTimeout8};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge FCLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus(input logic b, input logic cs, input logic pw);
    BACT = b; IOCS = cs; IOPWCS = pw;
  endtask

  initial begin
    // Reset and idle
    #2;
    chk("reset_outs", 32'(outs()), 0);
    chk("reset_state", 32'(dut.state_q), 0);
    tick();
    nRES = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("idle_outs_%0d", i), 32'(outs()), 0);
    end

    // Posted write, edge A accepts
    bus(1, 1, 1);
    tick();                                        // A
    chk("pw_ale_ioreq_pwr", 32'(outs()), 32'b110100);
    tick();                                        // A+1
    chk("pw_req_hold", 32'(outs()), 32'b100100);
    IOACT = 1'b1;
    tick();                                        // A+2
    chk("pw_ready_held", 32'(IOPWReady), 1);
    bus(0, 0, 0);
    tick();                                        // A+3
    chk("pw_ready_cleared", 32'(IOPWReady), 0);
    tick();                                        // A+4
    chk("pw_act_ioreq_low", 32'(IOREQ), 0);
    ticks(3);                                      // A+7
    IOACT = 1'b0;
    ticks(2);                                      // A+9
    chk("pw_still_act", 32'(dut.state_q), 2);
    tick();                                        // A+10
    chk("pw_idle_after_3", 32'(dut.state_q), 0);
    chk("pw_no_np_rdle", 32'(outs()), 0);

    // Read, edge B accepts
    bus(1, 1, 0);
    tick();                                        // B
    chk("rd_ale_ioreq", 32'(outs()), 32'b110000);
    tick();                                        // B+1
    IOACT = 1'b1;
    ticks(2);                                      // B+3
    chk("rd_ioreq_before_act", 32'(IOREQ), 1);
    tick();                                        // B+4
    chk("rd_ioreq_drop", 32'(IOREQ), 0);
    tick();                                        // B+5
    IOACT = 1'b0;
    ticks(2);                                      // B+7
    chk("rd_not_yet_ready", 32'(outs()), 0);
    tick();                                        // B+8
    chk("rd_npready_rdle", 32'(outs()), 32'b001010);
    tick();                                        // B+9
    chk("rd_rdle_one_cycle", 32'(outs()), 32'b000010);
    bus(0, 0, 0);
    tick();                                        // B+10
    chk("rd_ready_cleared", 32'(IONPReady), 0);

    // Back-to-back posted writes, edge C accepts the first
    bus(1, 1, 1);
    tick();                                        // C
    chk("b2b_first_ale", 32'(outs()), 32'b110100);
    IOACT = 1'b1;
    tick();                                        // C+1
    bus(0, 0, 0);
    tick();                                        // C+2
    bus(1, 1, 1);
    tick();                                        // C+3
    chk("b2b_stall_c3", 32'(outs()), 0);
    tick();                                        // C+4
    IOACT = 1'b0;
    ticks(2);                                      // C+6
    chk("b2b_stall_c6", 32'(IOPWReady), 0);
    tick();                                        // C+7
    chk("b2b_idle", 32'(dut.state_q), 0);
    chk("b2b_stall_c7", 32'(outs()), 0);
    tick();                                        // C+8
    chk("b2b_second_accept", 32'(outs()), 32'b110100);
    IOACT = 1'b1;
    tick();                                        // C+9
    bus(0, 0, 0);
    ticks(2);                                      // C+11
    chk("b2b_second_act", 32'(dut.state_q), 2);
    IOACT = 1'b0;
    ticks(3);                                      // C+14
    chk("b2b_second_idle", 32'(dut.state_q), 0);

    // Fresh reset before the watchdog case
    nRES = 1'b0;
    tick();
    nRES = 1'b1;
    tick();

    // Watchdog on TIMEOUT=8 instance, edge T accepts, IOACT never rises
    bus(1, 1, 0);
    tick();                                        // T
    chk("to_ioreq_rise", 32'(outs8()), 32'b110000);
    ticks(7);                                      // T+7
    chk("to_before_fire", 32'(outs8()), 32'b100000);
    tick();                                        // T+8
    chk("to_fire", 32'(outs8()), 32'b000011);
    chk("to_default_still_req", 32'(IOREQ), 1);
    tick();                                        // T+9
    chk("to_after_fire", 32'(outs8()), 32'b000010);
    bus(0, 0, 0);
    tick();
    chk("to_ready_cleared", 32'(IONPReady8), 0);

    // Reset during ACT of a posted write (BACT held so IOPWReady is high)
    nRES = 1'b0;
    tick();
    nRES = 1'b1;
    tick();
    bus(1, 1, 1);
    tick();                                        // R
    IOACT = 1'b1;
    ticks(3);                                      // R+3
    chk("rst_pre_act", 32'(dut.state_q), 2);
    chk("rst_pre_pwready", 32'(outs()), 32'b000100);
    #2;
    nRES = 1'b0;
    #2;
    chk("rst_async_outs", 32'(outs()), 0);
    chk("rst_async_state", 32'(dut.state_q), 0);
    IOACT = 1'b0;
    bus(0, 0, 0);
    #2;
    nRES = 1'b1;
    tick();

    // Read after reset, edge N accepts
    bus(1, 1, 0);
    tick();                                        // N
    chk("post_rst_ale", 32'(outs()), 32'b110000);
    tick();                                        // N+1
    IOACT = 1'b1;
    ticks(4);                                      // N+5
    IOACT = 1'b0;
    ticks(3);                                      // N+8
    chk("post_rst_done", 32'(outs()), 32'b001010);
    tick();                                        // N+9
    chk("post_rst_rdle_off", 32'(RDLE), 0);
    bus(0, 0, 0);
    tick();
    chk("post_rst_idle", 32'(outs()), 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
